// File: rtl/matrix_operand_loader_if.sv
// Operand-stream and matrix/vector output bundle for matrix_operand_loader.
// reuse_a exists only when MATRIX_LOADER_REUSE_A_EN is defined.
interface matrix_operand_loader_if #(
   parameter int W = 7,
   parameter int N = 4
);
   logic             in_valid;
   logic [W-1:0]     in_data;
   logic             in_ready;
   logic [N*N*W-1:0] a_out;
   logic [N*W-1:0]   b_out;
   logic             operands_valid;
   logic             operands_ack;
   logic [4:0]       load_count;
`ifdef MATRIX_LOADER_REUSE_A_EN
   logic             reuse_a;

   modport master (
      output in_valid, in_data, operands_ack, reuse_a,
      input  in_ready, a_out, b_out, operands_valid, load_count
   );

   modport slave (
      input  in_valid, in_data, operands_ack, reuse_a,
      output in_ready, a_out, b_out, operands_valid, load_count
   );
`else
   modport master (
      output in_valid, in_data, operands_ack,
      input  in_ready, a_out, b_out, operands_valid, load_count
   );

   modport slave (
      input  in_valid, in_data, operands_ack,
      output in_ready, a_out, b_out, operands_valid, load_count
   );
`endif
endinterface

// File: rtl/matrix_operand_loader.sv
// Fills an NxN matrix and N-vector from a valid/ready word stream, then holds them until acked.
// Optional MATRIX_LOADER_REUSE_A_EN: ack with reuse_a=1 keeps the matrix and reloads only the vector.
module matrix_operand_loader #(
   parameter int W = 7,
   parameter int N = 4
) (
   input logic                    clk,
   input logic                    rst,
   matrix_operand_loader_if.slave bus
);
   localparam int NA = N * N;
   localparam int NF = N * N + N;
   localparam logic [4:0] A_LAST = 5'(NA - 1);
   localparam logic [4:0] F_LAST = 5'(NF - 1);
   localparam logic [4:0] B_BASE = 5'(NA);

   typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_e;

   state_e            state_q, state_d;
   logic [NA*W-1:0]   a_q, a_d;
   logic [N*W-1:0]    b_q, b_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [4:0]        b_idx;
   logic              ready;
   logic              reuse;

`ifdef MATRIX_LOADER_REUSE_A_EN
   assign reuse = bus.reuse_a;
`else
   assign reuse = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ready   = 1'b0;
      b_idx   = cnt_q - B_BASE;
      case (state_q)
         IDLE: state_d = LOAD_A;
         LOAD_A: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               a_d[cnt_q*W +: W] = bus.in_data;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == A_LAST) state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               b_d[b_idx*W +: W] = bus.in_data;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == F_LAST) begin
                  cnt_d   = '0;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.operands_ack) begin
               valid_d = 1'b0;
               // Reuse skips straight to the vector words, keeping a_out intact.
               if (reuse) begin
                  state_d = LOAD_B;
                  cnt_d   = B_BASE;
               end else begin
                  state_d = LOAD_A;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.in_ready       = ready;
   assign bus.a_out          = a_q;
   assign bus.b_out          = b_q;
   assign bus.operands_valid = valid_q;
   assign bus.load_count     = cnt_q;
endmodule
